vec_lane_serializer: RTL
========================

Name: vec_lane_serializer

Overview:
- Downstream stage of the three-lane vector combiner. Consumes its 41-bit C result bus and emits it as a stream of 12-bit lane beats with a valid/ready handshake.
- Lanes 0..2 map to bits [11:0], [23:12], [35:24]. Undriven tail bits [40:36] ride as sideband on the last beat.
- Double-buffered: one active word plus one pending word, so upstream is throttled only when both are occupied.

Parameters:
- LANE_W, 12, bits per lane beat
- NUM_LANES, 3, lanes per input word
- IN_W, 41, input bus width; must be >= LANE_W*NUM_LANES
- TAIL_W, IN_W-LANE_W*NUM_LANES (=5), sideband width; derived, not overridable
- CNT_W, 16, width of the completed-word counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a word
- in_ready  output  1  block can accept a word this cycle
- in_data  input  IN_W  combiner C bus
- out_valid  output  1  out_lane is valid
- out_ready  input  1  consumer accepts beat
- out_lane  output  LANE_W  current lane slice
- out_idx  output  2  lane index 0..NUM_LANES-1
- out_last  output  1  beat is the final lane of the word
- out_tail  output  TAIL_W  in_data[IN_W-1:LANE_W*NUM_LANES] of active word; valid only when out_last=1, else 0
- word_cnt  output  CNT_W  words fully transmitted, saturating

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, pend_valid=0, lane counter=0, word_cnt=0. Outputs: out_valid=0, out_lane=0, out_idx=0, out_last=0, out_tail=0, in_ready=1.
- Reset mid-word discards both active and pending words; no partial beats after deassert.
- Accept: in_fire = in_valid & in_ready. Out accept: out_fire = out_valid & out_ready.
- in_ready = ~pend_valid (registered-state only; no combinational path from out_ready).
- FSM IDLE:
  - out_valid=0.
  - in_fire loads the active register, sets idx=0, moves to SEND.
  - Latency: accept in cycle N gives lane 0 on out_valid in cycle N+1.
- FSM SEND:
  - out_valid=1; out_lane=active[idx*LANE_W +: LANE_W]; out_last=(idx==NUM_LANES-1).
  - Outputs are held stable while out_ready=0.
  - out_fire with idx<NUM_LANES-1: idx increments.
  - out_fire on last lane: word_cnt increments, saturating at all-ones. Then:
    - If pend_valid: load pend into active, clear pend_valid, idx=0, stay in SEND (back-to-back, no bubble).
    - Else if in_fire same cycle: load in_data into active directly, idx=0, stay in SEND.
    - Else: go to IDLE.
  - in_fire while in SEND without the last-lane handoff above: store into pend, set pend_valid.
- Simultaneous: pend loaded and pend drained in the same cycle cannot occur, because in_ready=0 while pend_valid=1.
- Throughput: one beat per cycle sustained with out_ready=1. One word per NUM_LANES cycles, no gaps between words.
- No data reordering, no drops. Every accepted word yields exactly NUM_LANES beats in idx order.
- X on in_data when in_valid=0 must not propagate into registers.

Decomposition:
- Package vec_ser_pkg holds:
  - LANE_W, NUM_LANES, IN_W, derived TAIL_W.
  - Enum state_e {IDLE, SEND}.
  - Function lane_slice(word, idx).
- One natural sub-module, vec_word_buf: a single-entry pending register with load/clear and a valid flag. Instantiated once for pend.
- The FSM, active register and counter stay in the top.

Test Plan:
- Reset then single word: in_data=41'h1F_ABC_123_456 with out_ready=1 -> out_lane 0x456, 0x123, 0xABC, idx 0,1,2, out_last only on third beat with out_tail=5'h1F. Then word_cnt=1 and IDLE.
- Back-to-back: three words pushed every cycle, out_ready=1 -> 9 consecutive beats with no bubble; in_ready drops to 0 once pend is filled; word_cnt=3.
- Backpressure: out_ready=0 for 5 cycles mid-word at idx=1 -> out_lane/out_idx hold 0x123/1. A second in_fire fills pend, then in_ready=0 and a third in_valid is held off. Releasing resumes with no loss.
- Last-beat plus input: pend empty, last-lane out_fire coincides with in_fire of 41'h0_000_000_FFF -> next cycle out_lane=0xFFF, idx=0.
- Reset mid-word: assert rst_n=0 asynchronously after lane 1 with pend full -> out_valid=0 immediately, in_ready=1, word_cnt=0. No stale beats after release.
- Saturation: force 65 536 words (or CNT_W=4 with 17 words) -> word_cnt sticks at all-ones.

Source files
------------

// File: rtl/vec_ser_pkg.sv
// Shared constants, FSM state type and lane slicing helper for the lane serializer.
package vec_ser_pkg;

   localparam int unsigned LANE_W    = 12;
   localparam int unsigned NUM_LANES = 3;
   localparam int unsigned IN_W      = 41;
   localparam int unsigned TAIL_W    = IN_W - LANE_W * NUM_LANES;
   localparam int unsigned IDX_W     = 2;

   typedef enum logic [0:0] {IDLE, SEND} state_e;

   function automatic logic [LANE_W-1:0] lane_slice(input logic [IN_W-1:0]  word,
                                                    input logic [IDX_W-1:0] idx);
      return word[int'(idx) * LANE_W +: LANE_W];
   endfunction

endpackage

// File: rtl/vec_word_buf.sv
// Single-entry holding register with a valid flag; load wins over clear.
module vec_word_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/vec_lane_serializer.sv
// Splits each combiner word into NUM_LANES lane beats; one active word plus one
// pending word so upstream only stalls when both slots are occupied.
module vec_lane_serializer
   import vec_ser_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANE_W-1:0] out_lane,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last,
   output logic [TAIL_W-1:0] out_tail,
   output logic [CNT_W-1:0]  word_cnt
);

   state_e             state_q;
   logic [IN_W-1:0]    active_q;
   logic [IDX_W-1:0]   idx_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               pend_valid;
   logic [IN_W-1:0]    pend_data;

   logic sending, lane_last, in_fire, out_fire, word_done, pend_load, pend_clear;

   assign sending   = (state_q == SEND);
   assign lane_last = (idx_q == IDX_W'(NUM_LANES - 1));

   // in_ready depends on registered state only, never on out_ready.
   assign in_ready  = ~pend_valid;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = sending & out_ready;
   assign word_done = out_fire & lane_last;

   // A word arriving on the final beat with pend empty goes straight to active.
   assign pend_load  = in_fire & sending & ~word_done;
   assign pend_clear = word_done & pend_valid;

   vec_word_buf #(
      .W (IN_W)
   ) u_pend (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (pend_load),
      .clear (pend_clear),
      .din   (in_data),
      .dout  (pend_data),
      .valid (pend_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         active_q <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_fire) begin
                  active_q <= in_data;
                  idx_q    <= '0;
                  state_q  <= SEND;
               end
            end
            SEND: begin
               if (out_fire && !lane_last) begin
                  idx_q <= idx_q + 1'b1;
               end else if (word_done) begin
                  if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                  idx_q <= '0;
                  if (pend_valid) begin
                     active_q <= pend_data;
                  end else if (in_fire) begin
                     active_q <= in_data;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid = sending;
   assign out_lane  = sending ? lane_slice(active_q, idx_q) : '0;
   assign out_idx   = sending ? idx_q : '0;
   assign out_last  = sending & lane_last;
   assign out_tail  = (sending && lane_last) ? active_q[IN_W-1 -: TAIL_W] : '0;
   assign word_cnt  = cnt_q;

endmodule
